// File: rtl/actsel_pkg.sv
// actsel_pkg: shared sizes, LFSR seed and FSM state type for the action selector.
package actsel_pkg;
    localparam int Q_W = 16;
    localparam int NUM_ACT = 15;
    localparam int ACT_W = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_e;
endpackage

// File: rtl/actsel_lfsr.sv
// actsel_lfsr: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
module actsel_lfsr (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);
    import actsel_pkg::*;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[0], lfsr[15], lfsr[14] ^ lfsr[0], lfsr[13] ^ lfsr[0],
                          lfsr[12], lfsr[11] ^ lfsr[0], lfsr[10:1]};
    end
endmodule

// File: rtl/action_selector.sv
// action_selector: scans the Q-table for the argmax action, optionally epsilon-greedy.
// Exploration (LFSR + eps threshold) is built only when ACTSEL_EXPLORE_EN is defined.
module action_selector #(
    parameter int Q_W     = actsel_pkg::Q_W,
    parameter int NUM_ACT = actsel_pkg::NUM_ACT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    eps,
    output logic                          q_rd,
    output logic [actsel_pkg::ACT_W-1:0]  q_addr,
    input  logic signed [Q_W-1:0]         q_data,
    output logic [actsel_pkg::ACT_W-1:0]  at,
    output logic                          at_valid,
    output logic                          busy
);
    import actsel_pkg::*;
    localparam logic [ACT_W-1:0] LAST = ACT_W'(NUM_ACT - 1);
    state_e                 state_q;
    logic signed [Q_W-1:0]  best_q;
    logic [ACT_W-1:0]       best_idx_q, cmp_idx_q, at_d;
    logic                   cmp_vld_q, take;
    // address 0 seeds best unconditionally, so all-negative tables work
    assign take = cmp_vld_q && (cmp_idx_q == '0 || q_data > best_q);
`ifdef ACTSEL_EXPLORE_EN
    logic [15:0] lfsr;
    logic [7:0]  eps_q;
    actsel_lfsr u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          eps_q <= '0;
        else if (state_q == IDLE && start) eps_q <= eps;
    end
    assign at_d = (lfsr[7:0] < eps_q) ? ((lfsr[11:8] == 4'hF) ? 4'hE : lfsr[11:8]) : best_idx_q;
`else
    logic unused_eps;
    assign unused_eps = ^eps;
    assign at_d = best_idx_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            q_rd       <= 1'b0;
            q_addr     <= '0;
            at         <= '0;
            at_valid   <= 1'b0;
            busy       <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            cmp_idx_q  <= '0;
            cmp_vld_q  <= 1'b0;
        end else begin
            cmp_vld_q <= q_rd;
            cmp_idx_q <= q_addr;
            if (take) begin
                best_q     <= q_data;
                best_idx_q <= cmp_idx_q;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SCAN;
                    busy    <= 1'b1;
                    q_rd    <= 1'b1;
                end
                SCAN: begin
                    if (q_rd) begin
                        q_rd   <= q_addr != LAST;
                        q_addr <= (q_addr == LAST) ? '0 : q_addr + ACT_W'(1);
                    end
                    if (cmp_vld_q && cmp_idx_q == LAST) state_q <= DECIDE;
                end
                DECIDE: begin
                    at       <= at_d;
                    at_valid <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    at_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_action_selector.sv
// tb_action_selector: directed vectors against hand-computed greedy results and an LFSR model.
module tb_action_selector;
    logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0]        eps = 8'd0;
    logic              q_rd, at_valid, busy;
    logic [3:0]        q_addr, at;
    logic signed [15:0] q_data;
    logic signed [15:0] q_mem [15];
    logic [15:0]       lfsr_m;
    int                vecs = 0, errs = 0;

    action_selector dut (
        .clk(clk), .rst(rst), .start(start), .eps(eps), .q_rd(q_rd), .q_addr(q_addr),
        .q_data(q_data), .at(at), .at_valid(at_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) q_data <= q_mem[q_addr];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
    always @(posedge clk or posedge rst) lfsr_m <= rst ? 16'hACE1 : lfsr_step(lfsr_m);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic signed [15:0] base, input int step, input int hot, input logic signed [15:0] hot_val);
        for (int i = 0; i < 15; i++) q_mem[i] = (i == hot) ? hot_val : 16'(base + step * i);
    endtask

    task automatic run(input logic [7:0] e, input logic [3:0] greedy, input int restart_cyc);
        logic [3:0] exp_at;
        exp_at = greedy;
        eps = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        eps = 8'd0;
        for (int k = 1; k <= 22; k++) begin
            if (k <= 16) begin
                check("q_rd", q_rd, k <= 15);
                check("q_addr", q_addr, (k <= 15) ? k - 1 : 0);
            end
            check("busy", busy, k <= 18);
            check("at_valid", at_valid, k == 18);
`ifdef ACTSEL_EXPLORE_EN
            if (k == 17 && lfsr_m[7:0] < e) exp_at = (lfsr_m[11:8] == 4'hF) ? 4'hE : lfsr_m[11:8];
`endif
            if (k == 18) check("at", at, exp_at);
            if (k == 22) check("at_hold", at, exp_at);
            start = (k == restart_cyc);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fill(0, 10, -1, 0);
        tick();
        tick();
        check("rst_at", at, 0);
        check("rst_at_valid", at_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_q_rd", q_rd, 0);
        check("rst_q_addr", q_addr, 0);
        rst = 1'b0;
        run(8'd0, 4'd14, 0);
        fill(100, 0, -1, 0);
        run(8'd0, 4'd0, 0);
        fill(-500, 0, 7, -1);
        run(8'd0, 4'd7, 0);
        fill(0, 10, -1, 0);
        run(8'd255, 4'd14, 0);
        fill(-500, 0, 7, -1);
        run(8'd0, 4'd7, 5);
        fill(0, 10, -1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_q_rd", q_rd, 0);
        check("abort_q_addr", q_addr, 0);
        check("abort_at", at, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("abort_at_valid", at_valid, 0);
            check("abort_busy_hold", busy, 0);
        end
        rst = 1'b0;
        run(8'd0, 4'd14, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
